// File: rtl/prog_loader_pkg.sv
// Shared FSM state encoding and default parameter values for the program loader.
package prog_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_CHECK = 3'd2,
      ST_RUN   = 3'd3,
      ST_ERR   = 3'd4
   } state_e;

   localparam int DEF_DATA_W    = 16;
   localparam int DEF_ADDR_W    = 16;
   localparam int DEF_BASE_ADDR = 32'h0000_0100;
   localparam int DEF_ADDR_STEP = 2;
   localparam int DEF_MAX_WORDS = 256;
   localparam bit DEF_CHK_EN    = 1'b1;

   // Width of a counter that must represent 0..max_words inclusive.
   function automatic int cnt_w(input int max_words);
      return $clog2(max_words + 1);
   endfunction

endpackage

// File: rtl/prog_chksum.sv
// Running modulo-2^DATA_W sum of payload words, with synchronous clear.
module prog_chksum #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_i,
   input  logic              add_en_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] sum_o
);

   logic [DATA_W-1:0] sum_q;

   // Accumulator register; clear wins over add.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
      end else if (clear_i) begin
         sum_q <= '0;
      end else if (add_en_i) begin
         sum_q <= sum_q + data_i;
      end else begin
         sum_q <= sum_q;
      end
   end

   assign sum_o = sum_q;

endmodule

// File: rtl/prog_loader.sv
// Streaming program loader: writes a word stream into instruction memory,
// optionally verifies a trailing checksum, then releases the CPU.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int                DATA_W    = DEF_DATA_W,
   parameter int                ADDR_W    = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
   parameter int                ADDR_STEP = DEF_ADDR_STEP,
   parameter int                MAX_WORDS = DEF_MAX_WORDS,
   parameter bit                CHK_EN    = DEF_CHK_EN
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          abort,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_W-1:0]             in_data,
   input  logic                          in_last,
   output logic                          mem_we,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   output logic                          cpu_run,
   output logic                          busy,
   output logic                          done,
   output logic                          error,
   output logic [cnt_w(MAX_WORDS)-1:0]   words_loaded
);

   localparam int                CNT_W   = cnt_w(MAX_WORDS);
   localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_WORDS);
   localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(ADDR_STEP);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] chk_q, chk_d;
   logic              drain_q, drain_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              run_q, run_d;

   logic              accept_s;
   logic              sum_clr_s;
   logic              sum_add_s;
   logic [DATA_W-1:0] sum_s;

   prog_chksum #(.DATA_W(DATA_W)) u_chksum (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear_i  (sum_clr_s),
      .add_en_i (sum_add_s),
      .data_i   (in_data),
      .sum_o    (sum_s)
   );

   // drain_q marks the write cycle of a final payload beat: LOAD stops accepting
   // and moves to RUN only once that write is on the bus.
   assign in_ready = (state_q == ST_LOAD) && !drain_q;
   assign busy     = (state_q == ST_LOAD) || (state_q == ST_CHECK);
   assign done     = (state_q == ST_RUN);
   assign error    = (state_q == ST_ERR);
   assign accept_s = in_valid && in_ready;

   // Next-state, write-port and counter logic; abort overrides everything.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      chk_d     = chk_q;
      drain_d   = drain_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      run_d     = 1'b0;
      sum_clr_s = 1'b0;
      sum_add_s = 1'b0;

      if (abort) begin
         state_d = ST_IDLE;
         drain_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d   = ST_LOAD;
                  ptr_d     = BASE_ADDR;
                  cnt_d     = '0;
                  drain_d   = 1'b0;
                  sum_clr_s = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_LOAD: begin
               if (drain_q) begin
                  state_d = ST_RUN;
                  drain_d = 1'b0;
               end else if (accept_s) begin
                  if (CHK_EN && in_last) begin
                     chk_d   = in_data;
                     state_d = ST_CHECK;
                  end else if (cnt_q == MAX_CNT) begin
                     state_d = ST_ERR;
                  end else begin
                     we_d      = 1'b1;
                     addr_d    = ptr_q;
                     wdata_d   = in_data;
                     ptr_d     = ptr_q + STEP;
                     cnt_d     = cnt_q + CNT_W'(1);
                     sum_add_s = 1'b1;
                     drain_d   = in_last;
                  end
               end else begin
                  state_d = ST_LOAD;
               end
            end
            ST_CHECK: begin
               if (chk_q == sum_s) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_ERR;
               end
            end
            ST_RUN:  state_d = ST_RUN;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
         endcase
      end

      run_d = (state_d == ST_RUN);
   end

   // State and registered-output flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= BASE_ADDR;
         cnt_q   <= '0;
         chk_q   <= '0;
         drain_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= BASE_ADDR;
         wdata_q <= '0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         chk_q   <= chk_d;
         drain_q <= drain_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         run_q   <= run_d;
      end
   end

   assign mem_we       = we_q;
   assign mem_addr     = addr_q;
   assign mem_wdata    = wdata_q;
   assign cpu_run      = run_q;
   assign words_loaded = cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench: four loader instances with different parameters share one
// input stream; each instance's memory writes are checked against a queue.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  start_v;
   logic [3:0]  abort_v;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_last;

   wire  [3:0]       rdy_v, we_v, run_v, busy_v, done_v, err_v;
   wire  [3:0][15:0] addr_a;
   wire  [3:0][15:0] data_a;
   wire  [8:0]       wl0, wl1, wl3;
   wire  [2:0]       wl2;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q [4][$];
   logic [15:0] img [23];

   always #5 clk = ~clk;

   prog_loader #(.CHK_EN(1'b0)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
      .in_valid(in_valid), .in_ready(rdy_v[0]), .in_data(in_data), .in_last(in_last),
      .mem_we(we_v[0]), .mem_addr(addr_a[0]), .mem_wdata(data_a[0]), .cpu_run(run_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .error(err_v[0]), .words_loaded(wl0));

   prog_loader #(.CHK_EN(1'b1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
      .in_valid(in_valid), .in_ready(rdy_v[1]), .in_data(in_data), .in_last(in_last),
      .mem_we(we_v[1]), .mem_addr(addr_a[1]), .mem_wdata(data_a[1]), .cpu_run(run_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .error(err_v[1]), .words_loaded(wl1));

   prog_loader #(.MAX_WORDS(4), .CHK_EN(1'b0)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort_v[2]),
      .in_valid(in_valid), .in_ready(rdy_v[2]), .in_data(in_data), .in_last(in_last),
      .mem_we(we_v[2]), .mem_addr(addr_a[2]), .mem_wdata(data_a[2]), .cpu_run(run_v[2]),
      .busy(busy_v[2]), .done(done_v[2]), .error(err_v[2]), .words_loaded(wl2));

   prog_loader #(.BASE_ADDR(16'hFFFC), .ADDR_STEP(2), .CHK_EN(1'b0)) u3 (
      .clk(clk), .rst_n(rst_n), .start(start_v[3]), .abort(abort_v[3]),
      .in_valid(in_valid), .in_ready(rdy_v[3]), .in_data(in_data), .in_last(in_last),
      .mem_we(we_v[3]), .mem_addr(addr_a[3]), .mem_wdata(data_a[3]), .cpu_run(run_v[3]),
      .busy(busy_v[3]), .done(done_v[3]), .error(err_v[3]), .words_loaded(wl3));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Status bits packed as {busy, done, error, cpu_run}.
   task automatic stat(input string nm, input int i, input logic [3:0] exp);
      chk(nm, {28'd0, busy_v[i], done_v[i], err_v[i], run_v[i]}, {28'd0, exp});
   endtask

   task automatic pulse_start(input int i);
      start_v[i] = 1'b1;
      @(negedge clk);
      start_v[i] = 1'b0;
   endtask

   task automatic pulse_abort(input int i);
      abort_v[i] = 1'b1;
      @(negedge clk);
      abort_v[i] = 1'b0;
   endtask

   // Present one beat; if wr is set, the expected write is queued for the monitor.
   task automatic send(input int i, input logic [15:0] d, input logic last,
                       input bit wr, input logic [15:0] a);
      int n;
      if (wr) exp_q[i].push_back({a, d});
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      n = 0;
      while (!rdy_v[i] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         failures++;
         $display("FAIL handshake_timeout: inst %0d in_ready stayed 0, required 1", i);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic load_img(input bit gaps);
      for (int k = 0; k < 23; k++) begin
         send(0, img[k], (k == 22), 1'b1, 16'h0100 + 16'(2 * k));
         if (gaps && k != 22) begin
            int g;
            g = (k % 5 == 2) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
            for (int j = 0; j < g; j++) begin
               if (j == 0 && k % 5 == 2) start_v[0] = 1'b1;
               @(negedge clk);
               start_v[0] = 1'b0;
            end
         end
      end
   endtask

   task automatic post_img(input string tag);
      stat({tag, "_wrcycle"}, 0, 4'b1000);
      @(negedge clk);
      stat({tag, "_run"}, 0, 4'b0101);
      chk({tag, "_we_idle"}, {31'd0, we_v[0]}, 32'd0);
      chk({tag, "_words"}, {23'd0, wl0}, 32'd23);
   endtask

   // Monitor: every write strobe must match the head of that instance's queue.
   always @(negedge clk) begin
      logic [31:0] e;
      for (int i = 0; i < 4; i++) begin
         if (rst_n && we_v[i]) begin
            if (exp_q[i].size() == 0) begin
               checks++;
               failures++;
               $display("FAIL wr_unexpected: inst %0d addr %h data %h, required no write",
                        i, addr_a[i], data_a[i]);
            end else begin
               e = exp_q[i].pop_front();
               chk($sformatf("wr_inst%0d", i), {addr_a[i], data_a[i]}, e);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      img[0] = 16'h2128;
      img[1] = 16'h312A;
      for (int k = 2; k < 22; k++) img[k] = img[k-1] + img[k-2];
      img[22] = 16'hFFFF;

      rst_n = 1'b0; start_v = 4'd0; abort_v = 4'd0;
      in_valid = 1'b0; in_data = 16'd0; in_last = 1'b0;
      repeat (3) @(negedge clk);

      // Reset values
      stat("rst_status", 0, 4'b0000);
      chk("rst_we", {28'd0, we_v}, 32'd0);
      chk("rst_ready", {28'd0, rdy_v}, 32'd0);
      chk("rst_addr0", {16'd0, addr_a[0]}, 32'h0100);
      chk("rst_addr3", {16'd0, addr_a[3]}, 32'hFFFC);
      chk("rst_words0", {23'd0, wl0}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Fibonacci image, no gaps
      pulse_start(0);
      stat("fib_load", 0, 4'b1000);
      load_img(1'b0);
      post_img("fib");

      // Abort from RUN, then same image with gaps and stray start pulses
      pulse_abort(0);
      stat("abort_idle", 0, 4'b0000);
      chk("abort_words_hold", {23'd0, wl0}, 32'd23);
      pulse_start(0);
      chk("restart_words", {23'd0, wl0}, 32'd0);
      load_img(1'b1);
      post_img("gap");

      // Asynchronous reset in the middle of a load
      pulse_abort(0);
      pulse_start(0);
      for (int k = 0; k < 5; k++) send(0, img[k], 1'b0, 1'b1, 16'h0100 + 16'(2 * k));
      #2 rst_n = 1'b0;
      #1;
      stat("midrst_status", 0, 4'b0000);
      chk("midrst_ready", {31'd0, rdy_v[0]}, 32'd0);
      chk("midrst_we", {31'd0, we_v[0]}, 32'd0);
      chk("midrst_addr", {16'd0, addr_a[0]}, 32'h0100);
      chk("midrst_words", {23'd0, wl0}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pulse_start(0);
      send(0, 16'hBEEF, 1'b0, 1'b1, 16'h0100);
      send(0, 16'h1234, 1'b0, 1'b1, 16'h0102);
      send(0, 16'h5678, 1'b1, 1'b1, 16'h0104);
      @(negedge clk);
      stat("postrst_run", 0, 4'b0101);
      chk("postrst_words", {23'd0, wl0}, 32'd3);

      // Checksum good: 0001+0002+FFFF = 0002 mod 2^16
      pulse_start(1);
      send(1, 16'h0001, 1'b0, 1'b1, 16'h0100);
      send(1, 16'h0002, 1'b0, 1'b1, 16'h0102);
      send(1, 16'hFFFF, 1'b0, 1'b1, 16'h0104);
      send(1, 16'h0002, 1'b1, 1'b0, 16'h0000);
      stat("chk_check", 1, 4'b1000);
      @(negedge clk);
      stat("chk_good_run", 1, 4'b0101);
      chk("chk_good_words", {23'd0, wl1}, 32'd3);

      // Checksum bad
      pulse_abort(1);
      pulse_start(1);
      send(1, 16'h0001, 1'b0, 1'b1, 16'h0100);
      send(1, 16'h0002, 1'b0, 1'b1, 16'h0102);
      send(1, 16'hFFFF, 1'b0, 1'b1, 16'h0104);
      send(1, 16'h0003, 1'b1, 1'b0, 16'h0000);
      @(negedge clk);
      stat("chk_bad_err", 1, 4'b0010);
      chk("chk_bad_words", {23'd0, wl1}, 32'd3);

      // Checksum-only load of zero words
      pulse_abort(1);
      pulse_start(1);
      send(1, 16'h0000, 1'b1, 1'b0, 16'h0000);
      @(negedge clk);
      stat("chk_empty_run", 1, 4'b0101);
      chk("chk_empty_words", {23'd0, wl1}, 32'd0);

      // Overflow: MAX_WORDS=4, fifth payload beat dropped
      pulse_start(2);
      for (int k = 0; k < 5; k++)
         send(2, 16'h00A0 + 16'(k), 1'b0, (k < 4), 16'h0100 + 16'(2 * k));
      stat("ovf_err", 2, 4'b0010);
      chk("ovf_words", {29'd0, wl2}, 32'd4);
      @(negedge clk);
      chk("ovf_queue", exp_q[2].size(), 32'd0);

      // Address wrap from FFFC, aborted load then full load
      pulse_start(3);
      send(3, 16'h0011, 1'b0, 1'b1, 16'hFFFC);
      send(3, 16'h0022, 1'b0, 1'b1, 16'hFFFE);
      send(3, 16'h0033, 1'b0, 1'b1, 16'h0000);
      @(negedge clk);
      pulse_abort(3);
      stat("wrap_abort", 3, 4'b0000);
      chk("wrap_abort_words", {23'd0, wl3}, 32'd3);
      pulse_start(3);
      chk("wrap_restart_words", {23'd0, wl3}, 32'd0);
      send(3, 16'h0044, 1'b0, 1'b1, 16'hFFFC);
      send(3, 16'h0055, 1'b0, 1'b1, 16'hFFFE);
      send(3, 16'h0066, 1'b1, 1'b1, 16'h0000);
      @(negedge clk);
      stat("wrap_run", 3, 4'b0101);
      chk("wrap_words", {23'd0, wl3}, 32'd3);

      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) chk($sformatf("queue_empty%0d", i), exp_q[i].size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- DATA_W, 16, instruction/data word width.
- ADDR_W, 16, memory byte-address width.
- BASE_ADDR, 'h100, address of the first loaded word.
- ADDR_STEP, 2, address increment per word, in bytes.
- MAX_WORDS, 256, largest payload accepted.
- CHK_EN, 1, when 1 the in_last beat carries a checksum and is not written to memory.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, pulse that begins a load.
- abort, in, 1, pulse that returns to IDLE from any state.
- in_valid, in, 1, stream word valid.
- in_ready, out, 1, loader accepts the word.
- in_data, in, DATA_W, stream word.
- in_last, in, 1, final beat of the program.
- mem_we, out, 1, instruction-memory write strobe.
- mem_addr, out, ADDR_W, write address.
- mem_wdata, out, DATA_W, write data.
- cpu_run, out, 1, releases the CPU to execute from BASE_ADDR.
- busy, out, 1, high in LOAD or CHECK.
- done, out, 1, high in RUN.
- error, out, 1, high in ERR.
- words_loaded, out, clog2(MAX_WORDS+1), count of words written.

Function
REQ-003 SHALL implement states IDLE, LOAD, CHECK, RUN and ERR.
REQ-004 IDLE: SHALL go to LOAD on start, clearing words_loaded, the running sum and the address pointer (pointer set to BASE_ADDR).
REQ-005 start outside IDLE SHALL be ignored.
REQ-006 in_ready SHALL be 1 only in LOAD; a beat is accepted when in_valid and in_ready are both 1.
REQ-007 Each accepted payload beat SHALL produce exactly one write one cycle later: mem_we=1 for one cycle, mem_addr=pointer, mem_wdata=data. Then pointer += ADDR_STEP, modulo 2^ADDR_W, and words_loaded increments.
REQ-008 The running sum SHALL be the sum of payload words modulo 2^DATA_W.
REQ-009 CHK_EN=0: an accepted in_last beat is payload; LOAD SHALL go to RUN after its write cycle.
REQ-010 CHK_EN=1: an accepted in_last beat is the checksum, is not written, and LOAD SHALL go to CHECK.
REQ-011 CHECK SHALL last one cycle, then go to RUN if the checksum equals the running sum, else to ERR.
REQ-012 A payload beat that would be word MAX_WORDS+1 SHALL NOT be written; the FSM SHALL go to ERR.
REQ-013 CHK_EN=1 with in_last on the first beat SHALL be valid when the checksum is 0, giving zero words loaded.
REQ-014 RUN SHALL hold cpu_run=1 and stay until abort.
REQ-015 ERR SHALL hold error=1, cpu_run=0, and stay until abort.
REQ-016 abort SHALL take priority over every other event: next state IDLE, no write that cycle or after, cpu_run=0. A write already registered from the previous cycle still completes.
REQ-017 words_loaded SHALL hold its value in RUN and ERR until the next start.

Reset
REQ-018 rst_n low SHALL asynchronously force IDLE and all outputs to 0, with mem_addr=BASE_ADDR and words_loaded=0. This holds even mid-load; the partial load is abandoned.
REQ-019 Outputs SHALL be registered, except in_ready, busy, done and error, which are decoded from the state register.

Structure
REQ-020 The state enum and default parameter constants SHALL live in a shared package, prog_loader_pkg.
REQ-021 The checksum accumulator MAY be a sub-module, prog_chksum (clear, add enable, data, sum); all other logic SHALL be a single module.

Verification
REQ-022 Fibonacci image: CHK_EN=0, 23 words 2128,312A,...,FFFF, in_last on FFFF.
- Writes at 0x100..0x12C, step 2, in order.
- words_loaded=23; cpu_run=1 on the cycle after the final write.
REQ-023 CHK_EN=1, payload 0001,0002,FFFF, checksum 0002 -> RUN; with checksum 0003 -> ERR, error=1, cpu_run=0.
REQ-024 MAX_WORDS=4, five payload beats without in_last -> exactly 4 writes, then ERR.
REQ-025 Random in_valid gaps, plus start pulsed during LOAD -> write sequence identical to the gap-free run; start has no effect.
REQ-026 Abort after 3 beats, then a new start with BASE_ADDR=0xFFFC, ADDR_STEP=2 -> addresses FFFC, FFFE, 0000 (wrap).
REQ-027 rst_n dropped mid-load -> all outputs 0 immediately with no clock edge; a subsequent load behaves correctly.
